// File: rtl/serial_sub12_if.sv
// serial_sub12_if: operand/result handshake bundle for the bit-serial subtractor.
// master drives operands and accepts results; slave is the subtractor side.
interface serial_sub12_if #(
    parameter int W = 12
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   diff;
    logic         underflow;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, underflow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, underflow
    );
endinterface

// File: rtl/serial_sub12.sv
// serial_sub12: bit-serial unsigned a - b, one borrow cell, LSB first, W+1-bit result.
// Define SERIAL_SUB12_SAT_EN to clamp underflowing results to zero.
module serial_sub12 #(
    parameter int W     = 12,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_sub12_if.slave      bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_res;
    logic               r_bor;
    logic [CNT_W-1:0]   r_cnt;
    logic [W:0]         r_diff;
    logic               r_uf;
    logic               w_load;
    logic               w_step;
    logic               w_last;
    logic               w_d;
    logic               w_bor_n;
    logic [W-1:0]       w_res_n;
    logic [W:0]         w_diff_n;

    always_comb begin
        w_d      = r_a[0] ^ r_b[0] ^ r_bor;
        w_bor_n  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_bor);
        w_res_n  = {w_d, r_res[W-1:1]};
`ifdef SERIAL_SUB12_SAT_EN
        w_diff_n = w_bor_n ? '0 : {1'b0, w_res_n};
`else
        w_diff_n = {w_bor_n, w_res_n};
`endif
    end

    always_comb begin
        w_load = (r_state == IDLE) && bus.in_valid;
        w_step = (r_state == SHIFT);
        w_last = w_step && (r_cnt == CNT_W'(W - 1));
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_load ? SHIFT : IDLE;
            SHIFT:   w_next = w_last ? DONE : SHIFT;
            DONE:    w_next = bus.out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_bor  <= 1'b0;
            r_cnt  <= '0;
            r_diff <= '0;
            r_uf   <= 1'b0;
        end else if (w_load) begin
            r_a   <= bus.a;
            r_b   <= bus.b;
            r_res <= '0;
            r_bor <= 1'b0;
            r_cnt <= '0;
        end else if (w_step) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= w_res_n;
            r_bor <= w_bor_n;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_diff <= w_diff_n;
                r_uf   <= w_bor_n;
            end
        end
    end

    // Result registers only change on the final shift, so they hold through DONE.
    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.diff      = r_diff;
    assign bus.underflow = r_uf;
endmodule
